// File: rtl/xg_run_controller.sv
// rtl/xg_run_controller.sv - program-load and run supervisor for xgriscv cores
// Loads IMEM while the core is held in reset, releases it, then stops it on halt/stuck/timeout.
module xg_run_controller #(
  parameter int XLEN        = 32,
  parameter int AW          = 8,
  parameter int CW          = 32,
  parameter int RST_HOLD    = 2,
  parameter int MAX_CYCLES  = 4096,
  parameter int STUCK_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [XLEN-1:0] halt_pc,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  output logic            ld_ready,
  output logic            imem_we,
  output logic [AW-1:0]   imem_waddr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            core_rstn,
  input  logic [XLEN-1:0] pc_w,
  output logic            busy,
  output logic            done,
  output logic            halted,
  output logic            stuck,
  output logic            timeout,
  output logic            load_trunc,
  output logic [AW:0]     words_loaded,
  output logic [CW-1:0]   cycle_count
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int SW = (STUCK_LIMIT > 1) ? $clog2(STUCK_LIMIT) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0] STUCK_LAST = SW'((STUCK_LIMIT > 0) ? STUCK_LIMIT - 1 : 0);
  localparam logic [CW-1:0] CYC_LAST   = CW'(MAX_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_LAST  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] halt_q;
  logic [XLEN-1:0] prev_pc;
  logic [SW-1:0]   stuck_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            core_rstn_q;

  logic start_ok;
  logic at_cap;
  logic first_run;
  logic pc_same;
  logic hit_halt;
  logic hit_stuck;
  logic hit_timeout;

  assign start_ok    = start && (state == S_IDLE || state == S_DONE);
  assign at_cap      = (words_loaded[AW-1:0] == ADDR_LAST);
  assign first_run   = (cycle_count == '0);
  // prev_pc is meaningless on the first RUN cycle, so that cycle never counts as a repeat
  assign pc_same     = (pc_w == prev_pc) && !first_run;
  assign hit_halt    = (pc_w == halt_q);
  assign hit_stuck   = (STUCK_LIMIT != 0) && pc_same && (stuck_cnt == STUCK_LAST);
  assign hit_timeout = (cycle_count == CYC_LAST);
  assign core_rstn   = core_rstn_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      core_rstn_q <= 1'b0;
    end else begin
      state       <= next_state;
      core_rstn_q <= (next_state == S_RUN);
    end
  end

  always_comb begin
    next_state = state;
    ld_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (ld_valid) begin
          imem_we    = 1'b1;
          imem_waddr = words_loaded[AW-1:0];
          imem_wdata = ld_data;
          if (ld_last || at_cap) next_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        busy = 1'b1;
        if (hold_cnt == HOLD_LAST) next_state = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (hit_halt || hit_stuck || hit_timeout) next_state = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) next_state = S_LOAD;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_q       <= '0;
      prev_pc      <= '0;
      stuck_cnt    <= '0;
      hold_cnt     <= '0;
      halted       <= 1'b0;
      stuck        <= 1'b0;
      timeout      <= 1'b0;
      load_trunc   <= 1'b0;
      words_loaded <= '0;
      cycle_count  <= '0;
    end else begin
      prev_pc <= pc_w;
      if (start_ok) begin
        halt_q       <= halt_pc;
        halted       <= 1'b0;
        stuck        <= 1'b0;
        timeout      <= 1'b0;
        load_trunc   <= 1'b0;
        words_loaded <= '0;
        cycle_count  <= '0;
      end
      if (imem_we) begin
        words_loaded <= words_loaded + 1'b1;
        if (!ld_last && at_cap) load_trunc <= 1'b1;
      end
      hold_cnt <= (state == S_RELEASE) ? hold_cnt + 1'b1 : '0;
      if (state == S_RUN) begin
        cycle_count <= cycle_count + 1'b1;
        stuck_cnt   <= pc_same ? stuck_cnt + 1'b1 : '0;
        // one flag per session, halt taking precedence over stuck over timeout
        if (hit_halt)         halted  <= 1'b1;
        else if (hit_stuck)   stuck   <= 1'b1;
        else if (hit_timeout) timeout <= 1'b1;
      end else begin
        stuck_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_xg_run_controller.sv
// tb/tb_xg_run_controller.sv - randomized session bench for xg_run_controller
module tb_xg_run_controller;

  localparam int XLEN = 32;
  localparam int AW   = 3;
  localparam int CW   = 32;
  localparam int HOLD = 2;
  localparam int MAXC = 16;
  localparam int CAP  = 1 << AW;

  logic            clk;
  logic            rstn;
  logic            start;
  logic [XLEN-1:0] halt_pc;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            ld_last;
  logic            ld_ready;
  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [XLEN-1:0] imem_wdata;
  logic            core_rstn;
  logic [XLEN-1:0] pc_w;
  logic            busy;
  logic            done;
  logic            halted;
  logic            stuck;
  logic            timeout;
  logic            load_trunc;
  logic [AW:0]     words_loaded;
  logic [CW-1:0]   cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] pcs   [0:17];
  logic [31:0] words [0:9];

  xg_run_controller #(
    .XLEN(XLEN), .AW(AW), .CW(CW), .RST_HOLD(HOLD), .MAX_CYCLES(MAXC), .STUCK_LIMIT(8)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .halt_pc(halt_pc),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rstn(core_rstn), .pc_w(pc_w), .busy(busy), .done(done),
    .halted(halted), .stuck(stuck), .timeout(timeout), .load_trunc(load_trunc),
    .words_loaded(words_loaded), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // First RUN cycle (1-based) on which halt, 9 equal consecutive PCs, or the 16th cycle occurs.
  function automatic void model(input logic [31:0] h, output int ke, output logic [2:0] fl);
    ke = MAXC;
    fl = 3'b001;
    for (int k = 1; k <= MAXC; k++) begin
      bit hh, ss, tt;
      hh = (pcs[k] == h);
      ss = 1'b0;
      if (k >= 9) begin
        ss = 1'b1;
        for (int j = k - 8; j < k; j++) if (pcs[j] != pcs[k]) ss = 1'b0;
      end
      tt = (k == MAXC);
      if (hh || ss || tt) begin
        ke = k;
        fl = hh ? 3'b100 : (ss ? 3'b010 : 3'b001);
        return;
      end
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, halted, stuck, timeout, load_trunc, core_rstn,
                          ld_ready, imem_we, imem_waddr, words_loaded}, 64'd0);
    check({tag, "_dat"}, {imem_wdata, cycle_count}, 64'd0);
  endtask

  // wmode: 0 directed 4-word program, 1 random length with last, 2 ten words without last
  // pmode: 0 halt, 1 stuck, 2 timeout, 3 random small-alphabet PCs
  task automatic run_session(input int wmode, input int pmode, input bit dir, input bit abort);
    int n, m, ke, low, k, a, base, k0;
    bit has_last, trunc;
    logic [31:0] h;
    logic [2:0] fl;

    if (wmode == 0) begin
      n = 4; has_last = 1'b1;
      words[0] = 32'h00000293; words[1] = 32'h00000313;
      words[2] = 32'h00128293; words[3] = 32'h00000067;
    end else begin
      has_last = (wmode == 1);
      n = has_last ? $urandom_range(1, 10) : 10;
      for (int i = 0; i < 10; i++) words[i] = $urandom;
    end
    m     = (n > CAP) ? CAP : n;
    trunc = (n > CAP);

    for (int i = 0; i < 18; i++) pcs[i] = 32'h0;
    case (pmode)
      0: begin
        h = dir ? 32'hC : 32'(4 * $urandom_range(0, 14));
        for (int i = 1; i < 18; i++) pcs[i] = 32'(4 * (i - 1));
      end
      1: begin
        base = dir ? 32'h10 : 4 * $urandom_range(0, 3);
        k0   = dir ? 1 : $urandom_range(1, 6);
        h    = 32'h100;
        for (int i = 1; i < 18; i++) pcs[i] = 32'(base + 4 * (((i < k0) ? i : k0) - 1));
      end
      2: begin
        h = 32'h100;
        for (int i = 1; i < 18; i++) pcs[i] = 32'(32'h40 + 4 * (i - 1));
      end
      default: begin
        h = 32'(4 * $urandom_range(0, 7));
        for (int i = 1; i < 18; i++) pcs[i] = 32'(4 * $urandom_range(0, 2));
      end
    endcase
    model(h, ke, fl);
    a = $urandom_range(1, ke);

    @(negedge clk);
    start = 1'b1; halt_pc = h;
    @(negedge clk);
    start = 1'b0; halt_pc = $urandom;
    check("start_ctl", {busy, done, halted, stuck, timeout, load_trunc, core_rstn}, 7'b1000000);
    check("start_cnt", {words_loaded, cycle_count}, 64'd0);

    for (int acc = 0, g = 0; acc < m && g < 80; g++) begin
      start   = ($urandom_range(0, 4) == 0);
      halt_pc = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0; ld_data = $urandom; ld_last = 1'b0;
        #1;
        check("gap_we", imem_we, 1'b0);
        check("gap_ready", ld_ready, 1'b1);
        check("gap_wl", words_loaded, acc);
      end else begin
        ld_valid = 1'b1; ld_data = words[acc]; ld_last = has_last && (acc == n - 1);
        #1;
        check("ld_ready", ld_ready, 1'b1);
        check("ld_we", imem_we, 1'b1);
        check("ld_addr", imem_waddr, acc);
        check("ld_data", imem_wdata, words[acc]);
        check("ld_wl", words_loaded, acc);
        acc++;
      end
      @(negedge clk);
    end
    start = 1'b0;

    low = 0;
    for (int t = 0; t < 8; t++) begin
      ld_valid = trunc ? 1'b1 : 1'($urandom_range(0, 1));
      ld_data  = $urandom; ld_last = 1'b0;
      #1;
      if (core_rstn) break;
      check("rel_ready", ld_ready, 1'b0);
      check("rel_we", imem_we, 1'b0);
      check("rel_wl", words_loaded, m);
      low++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    check("rel_len", low, HOLD);
    check("rel_trunc", load_trunc, trunc);
    check("run1_cc", cycle_count, 0);
    check("run1_busy", {busy, done}, 2'b10);

    k = 1;
    pc_w = pcs[1];
    for (int g = 0; g < 24; g++) begin
      if (abort && k == a) begin
        rstn = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      @(negedge clk);
      #1;
      if (k == ke) break;
      check("run_rstn", {core_rstn, done}, 2'b10);
      check("run_cc", cycle_count, k);
      k++;
      pc_w = pcs[k];
    end

    for (int t = 0; t < 3; t++) begin
      check("done_ctl", {done, busy, core_rstn}, 3'b100);
      check("done_flags", {halted, stuck, timeout}, fl);
      check("done_cc", cycle_count, ke);
      check("done_wl", {load_trunc, words_loaded}, {trunc, 4'(m)});
      pc_w = $urandom;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; halt_pc = '0; ld_valid = 1'b0;
    ld_data = '0; ld_last = 1'b0; pc_w = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;

    run_session(0, 0, 1'b1, 1'b0);
    run_session(1, 1, 1'b1, 1'b0);
    run_session(1, 2, 1'b1, 1'b0);
    run_session(2, 2, 1'b1, 1'b0);
    run_session(1, 3, 1'b0, 1'b1);
    run_session(0, 1, 1'b0, 1'b0);
    for (int s = 0; s < 40; s++) begin
      run_session($urandom_range(1, 2), $urandom_range(0, 3), 1'b0, ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xg_run_controller.md
Name: xg_run_controller

Overview:
- Synthesisable program-load and run supervisor for the xgriscv cores (single-cycle and pipelined).
- Streams a program into instruction memory through the IMEM write port while holding the core in reset, then releases the core.
- Watches the writeback PC for a halt address, a stuck PC or a cycle timeout, then freezes the core and reports status and cycle count.
- Replaces hard-coded bench preloads and fixed-address stops with a parametrised, reusable block.

Parameters:
XLEN, 32, PC and instruction word width
AW, 8, IMEM word-address width (depth 2^AW words)
CW, 32, cycle counter width
RST_HOLD, 2, cycles core_rstn stays low after load completes (minimum 1)
MAX_CYCLES, 4096, RUN-cycle timeout (must be below 2^CW)
STUCK_LIMIT, 8, consecutive identical pc_w comparisons that flag a stuck core; 0 disables the check

Ports:
clk  in  1  clock; all logic on rising edge
rstn  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a load/run session
halt_pc  in  XLEN  halt address, sampled on an accepted start
ld_valid  in  1  program word valid
ld_data  in  XLEN  program word
ld_last  in  1  marks the final program word
ld_ready  out  1  word accepted when ld_valid & ld_ready
imem_we  out  1  IMEM write enable
imem_waddr  out  AW  IMEM word address
imem_wdata  out  XLEN  IMEM write data
core_rstn  out  1  core reset, active low
pc_w  in  XLEN  core writeback PC
busy  out  1  state is not IDLE or DONE
done  out  1  session finished (high in DONE)
halted  out  1  ended on halt_pc
stuck  out  1  ended on stuck PC
timeout  out  1  ended on MAX_CYCLES
load_trunc  out  1  load ended at IMEM capacity without ld_last
words_loaded  out  AW+1  words written this session
cycle_count  out  CW  RUN cycles elapsed

Behaviour:
- Reset (asynchronous, rstn low):
  - State is IDLE.
  - All outputs 0, including core_rstn.
  - Internal halt_pc register, prev_pc and stuck counter cleared.
- States: IDLE, LOAD, RELEASE, RUN, DONE.
- IDLE / DONE:
  - start moves to LOAD, latches halt_pc, and clears halted/stuck/timeout/load_trunc, words_loaded and cycle_count.
  - start in any other state is ignored.
- LOAD:
  - ld_ready = 1.
  - On acceptance, in the same cycle (combinational): imem_we = 1, imem_waddr = words_loaded[AW-1:0], imem_wdata = ld_data. words_loaded increments on that edge.
  - imem_we = 0 whenever no word is accepted.
  - Accepted word with ld_last moves to RELEASE.
  - Accepted word at address 2^AW-1 without ld_last: set load_trunc, move to RELEASE; later words are not accepted.
  - ld_last at address 2^AW-1: load_trunc stays 0.
- RELEASE: core_rstn stays 0 for exactly RST_HOLD cycles, then RUN.
- RUN:
  - core_rstn = 1; cycle_count increments every cycle.
  - Halt: pc_w == halt_pc.
  - Stuck: pc_w == prev_pc for STUCK_LIMIT consecutive cycles. prev_pc <= pc_w every cycle. No comparison on the first RUN cycle.
  - Timeout: cycle_count + 1 == MAX_CYCLES.
  - Any condition moves to DONE next edge and sets exactly one flag. Priority: halted > stuck > timeout.
- DONE:
  - core_rstn = 0 (core frozen); done = 1.
  - Flags, cycle_count and words_loaded hold until the next start.
- core_rstn is registered and glitch-free. It is high only in RUN.
- Mid-session rstn assertion aborts immediately to the reset values above.

Test Plan:
- Load 4 words (0x00000293, 0x00000313, 0x00128293, 0x00000067 with ld_last), halt_pc = 0xC -> IMEM addresses 0..3 written, words_loaded = 4, core_rstn low 2 cycles then high, halted = 1 when pc_w = 0xC, cycle_count frozen, core_rstn = 0.
- RUN with pc_w held at 0x10 and halt_pc = 0x100, STUCK_LIMIT = 8 -> stuck = 1 after 8 equal comparisons (9th RUN cycle), halted = 0, timeout = 0.
- MAX_CYCLES = 16, pc_w incrementing by 4, never reaching halt_pc -> timeout = 1 with cycle_count = 16; DONE entered on the next edge.
- AW = 3, stream 10 words with no ld_last -> exactly 8 writes (addresses 0..7), load_trunc = 1, ld_ready = 0 after the 8th word, RUN follows.
- Same cycle pc_w == halt_pc and stuck threshold reached -> only halted = 1.
- start pulsed during LOAD -> ignored, words_loaded unaffected. rstn pulsed low mid-RUN -> all outputs 0, state IDLE. New start after DONE -> flags cleared, fresh load.
